// File: rtl/row_packer.sv
// Packs a stream of DATA_WIDTH results, lane 0 first, into SPAD_DATA_WIDTH scratchpad words
// written to consecutive addresses from a programmed base, with per-lane byte enables.
module row_packer #(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int DATA_WIDTH      = 8,
    parameter int SPAD_N          = SPAD_DATA_WIDTH / DATA_WIDTH,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_reg_clear,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_base_addr,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_flush,
    output logic [SPAD_DATA_WIDTH-1:0] o_spad_data,
    output logic [ADDR_WIDTH-1:0]      o_spad_addr,
    output logic [SPAD_N-1:0]          o_spad_be,
    output logic                       o_spad_valid,
    input  logic                       i_spad_ready,
    output logic                       o_busy,
    output logic                       o_done
);

    // state   | meaning
    // IDLE    | waiting for i_start
    // PACK    | accepting elements, emitting full words
    // FLUSH   | emitting any partial word, then finishing
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PACK  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int CNT_W = (SPAD_N > 1) ? $clog2(SPAD_N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPAD_N - 1);

    logic [1:0]                 state;
    logic [SPAD_DATA_WIDTH-1:0] asm_data;
    logic [SPAD_DATA_WIDTH-1:0] full_word;
    logic [CNT_W-1:0]           cnt;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [SPAD_N-1:0]          flush_be;
    logic                       accept;
    logic                       out_free;

    always_comb begin
        full_word = asm_data;
        full_word[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] = i_data;
    end

    always_comb begin
        flush_be = '0;
        for (int i = 0; i < SPAD_N; i++) begin
            flush_be[i] = (CNT_W'(i) < cnt);
        end
    end

    // Stall only when completing a word would overwrite an undelivered one.
    assign o_ready  = (state == ST_PACK) && !((cnt == LAST) && o_spad_valid && !i_spad_ready);
    assign accept   = i_valid && o_ready;
    assign out_free = !o_spad_valid || i_spad_ready;
    assign o_busy   = (state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_reg_clear) begin
            state        <= ST_IDLE;
            asm_data     <= '0;
            cnt          <= '0;
            addr         <= '0;
            o_spad_data  <= '0;
            o_spad_addr  <= '0;
            o_spad_be    <= '0;
            o_spad_valid <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (o_spad_valid && i_spad_ready) begin
                o_spad_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr     <= i_base_addr;
                        cnt      <= '0;
                        asm_data <= '0;
                        state    <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            o_spad_data  <= full_word;
                            o_spad_addr  <= addr;
                            o_spad_be    <= '1;
                            o_spad_valid <= 1'b1;
                            addr         <= addr + ADDR_WIDTH'(1);
                            cnt          <= '0;
                            asm_data     <= '0;
                        end else begin
                            asm_data <= full_word;
                            cnt      <= cnt + CNT_W'(1);
                        end
                    end
                    if (i_flush) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (cnt != '0) begin
                        // Unfilled lanes of asm_data are already zero.
                        if (out_free) begin
                            o_spad_data  <= asm_data;
                            o_spad_addr  <= addr;
                            o_spad_be    <= flush_be;
                            o_spad_valid <= 1'b1;
                            addr         <= addr + ADDR_WIDTH'(1);
                            cnt          <= '0;
                            asm_data     <= '0;
                        end
                    end else if (out_free) begin
                        o_done <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_row_packer.sv
// Scoreboard bench for row_packer: a small lane model queues expected words as elements are
// driven; a negedge monitor compares every presented word against the queue head.
module tb_row_packer;

    logic        clk = 1'b0;
    logic        i_rst, i_reg_clear, i_start, i_valid, i_flush, i_spad_ready;
    logic [7:0]  i_base_addr, i_data;
    logic        o_ready, o_spad_valid, o_busy, o_done;
    logic [63:0] o_spad_data;
    logic [7:0]  o_spad_addr, o_spad_be;

    row_packer dut (
        .i_clk(clk), .i_rst(i_rst), .i_reg_clear(i_reg_clear), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .o_spad_data(o_spad_data), .o_spad_addr(o_spad_addr),
        .o_spad_be(o_spad_be), .o_spad_valid(o_spad_valid), .i_spad_ready(i_spad_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  addr;
        logic [7:0]  be;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [63:0] m_word;
    int          m_cnt;
    logic [7:0]  m_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_done) done_cnt++;
        if (o_spad_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 64'd1, 64'd0);
            end else begin
                chk("spad_data", o_spad_data, sb[0].data);
                chk("spad_addr", {56'd0, o_spad_addr}, {56'd0, sb[0].addr});
                chk("spad_be", {56'd0, o_spad_be}, {56'd0, sb[0].be});
                if (i_spad_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input logic [7:0] base);
        m_word = '0;
        m_cnt  = 0;
        m_addr = base;
    endtask

    task automatic model_elem(input logic [7:0] d);
        exp_t e;
        m_word[m_cnt*8 +: 8] = d;
        m_cnt++;
        if (m_cnt == 8) begin
            e.data = m_word; e.addr = m_addr; e.be = 8'hFF;
            sb.push_back(e);
            m_addr = m_addr + 8'd1;
            m_word = '0;
            m_cnt  = 0;
        end
    endtask

    task automatic model_flush();
        exp_t e;
        if (m_cnt > 0) begin
            e.data = m_word; e.addr = m_addr; e.be = (8'd1 << m_cnt) - 8'd1;
            sb.push_back(e);
            m_addr = m_addr + 8'd1;
        end
        m_word = '0;
        m_cnt  = 0;
    endtask

    task automatic do_start(input logic [7:0] base);
        i_start = 1'b1;
        i_base_addr = base;
        cycle();
        i_start = 1'b0;
        chk("start_busy", {63'd0, o_busy}, 64'd1);
        chk("start_ready", {63'd0, o_ready}, 64'd1);
        model_reset(base);
    endtask

    task automatic push_elem(input logic [7:0] d, input logic fl);
        bit acc = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        i_flush = fl;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = o_ready;
            cycle();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        else model_elem(d);
        if (fl) model_flush();
    endtask

    task automatic flush_only();
        i_flush = 1'b1;
        cycle();
        i_flush = 1'b0;
        model_flush();
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int k = 0; k < 200 && done_cnt == d0; k++) cycle();
        repeat (4) cycle();
        chk(tag, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
    endtask

    initial begin
        int d0;
        i_rst = 1'b1; i_reg_clear = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
        i_spad_ready = 1'b1; i_base_addr = '0; i_data = '0;
        repeat (3) cycle();
        i_rst = 1'b0;
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd0);
        chk("rst_valid", {63'd0, o_spad_valid}, 64'd0);
        chk("rst_data", o_spad_data, 64'd0);
        chk("rst_addr", {56'd0, o_spad_addr}, 64'd0);
        chk("rst_be", {56'd0, o_spad_be}, 64'd0);
        chk("rst_done", {63'd0, o_done}, 64'd0);

        // i_valid in IDLE is ignored
        i_valid = 1'b1; i_data = 8'h77;
        repeat (3) cycle();
        chk("idle_ready", {63'd0, o_ready}, 64'd0);
        i_valid = 1'b0;

        // Full word, then flush with nothing left
        d0 = done_cnt;
        do_start(8'h10);
        for (int i = 1; i <= 8; i++) push_elem(8'(i), 1'b0);
        chk("full_latency", {63'd0, o_spad_valid}, 64'd1);
        flush_only();
        wait_done("full_done", d0);

        // Partial flush on the 11th element
        d0 = done_cnt;
        do_start(8'h20);
        for (int i = 1; i <= 10; i++) push_elem(8'(i), 1'b0);
        push_elem(8'h0B, 1'b1);
        chk("partial_t1", {63'd0, o_spad_valid}, 64'd0);
        cycle();
        chk("partial_t2", {63'd0, o_spad_valid}, 64'd1);
        wait_done("partial_done", d0);

        // Backpressure: output held for 20 cycles while 16 elements are offered
        d0 = done_cnt;
        do_start(8'h50);
        i_spad_ready = 1'b0;
        fork
            begin
                repeat (20) cycle();
                i_spad_ready = 1'b1;
            end
            begin
                for (int i = 1; i <= 15; i++) push_elem(8'(i), 1'b0);
                @(negedge clk);
                chk("bp_ready_low", {63'd0, o_ready}, 64'd0);
                cycle();
                push_elem(8'h10, 1'b0);
            end
        join
        flush_only();
        wait_done("bp_done", d0);

        // Address wrap
        d0 = done_cnt;
        do_start(8'hFF);
        for (int i = 0; i < 16; i++) push_elem(8'(8'hC0 + i), 1'b0);
        flush_only();
        wait_done("wrap_done", d0);

        // Empty run: o_done two cycles after flush, no word
        d0 = done_cnt;
        do_start(8'h33);
        flush_only();
        chk("empty_done_t1", {63'd0, o_done}, 64'd0);
        cycle();
        chk("empty_done_t2", {63'd0, o_done}, 64'd1);
        cycle();
        chk("empty_done_t3", {63'd0, o_done}, 64'd0);
        wait_done("empty_done", d0);

        // Mid-run reset drops the aborted run entirely
        d0 = done_cnt;
        do_start(8'h30);
        for (int i = 0; i < 5; i++) push_elem(8'(8'hA1 + i), 1'b0);
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        chk("midrst_busy", {63'd0, o_busy}, 64'd0);
        chk("midrst_valid", {63'd0, o_spad_valid}, 64'd0);
        repeat (5) cycle();
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        do_start(8'h40);
        for (int i = 0; i < 8; i++) push_elem(8'(8'h11 + i), 1'b0);
        flush_only();
        wait_done("midrst_done", d0);

        // i_reg_clear aborts the same way
        d0 = done_cnt;
        do_start(8'h60);
        for (int i = 0; i < 3; i++) push_elem(8'(i), 1'b0);
        i_reg_clear = 1'b1;
        cycle();
        i_reg_clear = 1'b0;
        model_reset(8'h00);
        chk("clr_busy", {63'd0, o_busy}, 64'd0);
        repeat (5) cycle();
        chk("clr_no_done", 64'(done_cnt - d0), 64'd0);
        chk("clr_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/row_packer.md
# row_packer

Output-side counterpart of the row router. It collects a stream of DATA_WIDTH results from one PE row and packs them, lane 0 first, into SPAD_DATA_WIDTH-wide scratchpad words. Each word is written to consecutive scratchpad addresses from a programmed base address, with per-lane byte enables so that a final partial word can be written. It sits between a PE row's output and the output scratchpad write arbiter.

## Interface
- SPAD_DATA_WIDTH, 64, scratchpad word width
- DATA_WIDTH, 8, element width
- SPAD_N, SPAD_DATA_WIDTH/DATA_WIDTH, lanes per word
- ADDR_WIDTH, 8, scratchpad word-address width

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  reset; synchronous, active-high
- i_reg_clear  in  1  synchronous clear; same effect as i_rst
- i_start  in  1  start a packing run (sampled in IDLE only)
- i_base_addr  in  ADDR_WIDTH  first word address of the run (sampled with i_start)
- i_data  in  DATA_WIDTH  result element
- i_valid  in  1  i_data valid
- o_ready  out  1  element accepted when i_valid & o_ready
- i_flush  in  1  end of run; emit any partial word, then finish
- o_spad_data  out  SPAD_DATA_WIDTH  packed word
- o_spad_addr  out  ADDR_WIDTH  word address
- o_spad_be  out  SPAD_N  per-lane write enable
- o_spad_valid  out  1  word valid
- i_spad_ready  in  1  arbiter accepts the word when o_spad_valid & i_spad_ready
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at run completion

## Operation
- Internal state: an assembly register (SPAD_N lanes plus a lane counter `cnt`), a one-word output register, an address counter `addr`, and an FSM with states IDLE, PACK and FLUSH.
- IDLE: o_ready=0. i_start loads addr=i_base_addr and cnt=0, then moves to PACK.
- PACK, element acceptance:
  - The accepted element is written to lane `cnt`, bits [cnt*DATA_WIDTH +: DATA_WIDTH].
  - cnt increments on each accepted element.
- PACK, word completion: on acceptance with cnt==SPAD_N-1:
  - the full word moves to the output register with be = all ones and address addr;
  - addr increments;
  - cnt returns to 0.
- o_ready in PACK = !(cnt==SPAD_N-1 && o_spad_valid && !i_spad_ready). This stalls input only when completing a word would overwrite an undelivered word.
- Flush in PACK: if an element is accepted in the same cycle as i_flush, it is included first. Then go to FLUSH; o_ready=0 from the next cycle.
- FLUSH:
  - If the assembly register holds cnt>0 lanes, it moves to the output register once the output register is free or draining. Only the filled lanes have be=1; unused lanes are driven to 0 in o_spad_data. addr increments.
  - When both the assembly and output registers are empty: pulse o_done and go to IDLE.
- Flush with cnt==0 and no element accepted: no word is emitted.
- Address arithmetic is modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH-1 wraps to 0.
- Output register rule: o_spad_data, o_spad_addr, o_spad_be and o_spad_valid stay stable while o_spad_valid & !i_spad_ready.
- Ignored inputs: i_start outside IDLE, i_flush outside PACK, and i_valid outside PACK.
- i_rst or i_reg_clear, at any point including mid-run, immediately aborts the run, drops pending data, clears all state, and no o_done is produced.

## Timing
- Reset values: state=IDLE, o_ready=0, o_spad_valid=0, o_spad_data=0, o_spad_addr=0, o_spad_be=0, o_busy=0, o_done=0; cnt=0, addr=0.
- i_start at cycle t: o_busy=1 and o_ready=1 at t+1.
- Latency: the element completing a word is accepted at t; o_spad_valid=1 at t+1.
- Throughput: with i_spad_ready held at 1, one element per cycle is sustained with no bubbles.
- Partial word after i_flush at t (output register free): o_spad_valid at t+2, one cycle later than the full-word path because it passes through FLUSH.
- o_done is asserted in the cycle after the handshake of the last word, or at t+2 when no word is pending. The return to IDLE coincides with o_done.
- Output register: a single-entry buffer with no combinational path from i_spad_ready to o_spad_valid. o_ready depends combinationally on i_spad_ready.

## Test plan
- Full word: SPAD_N=8, base 0x10, elements 0x01..0x08 back-to-back, i_spad_ready=1, then flush -> one word 0x0807060504030201 at addr 0x10 with be=0xFF. o_done pulses once and no second word appears.
- Partial flush: base 0x20, 11 elements 0x01..0x0B with i_flush on the 11th -> word at 0x20 (be=0xFF), then word 0x00000000000B0A09 at 0x21 with be=0x07, then o_done.
- Backpressure: i_spad_ready=0 for 20 cycles while 16 elements are offered -> the first word holds stable; o_ready drops on the 16th element; after release the two words arrive in order at base and base+1 with no data loss.
- Wrap: base 0xFF, 16 elements -> words at addr 0xFF, then 0x00.
- Empty run: i_start then immediate i_flush with no elements -> no o_spad_valid; o_done 2 cycles after i_flush.
- Mid-run reset: assert i_rst after 5 elements, then start a new run with base 0x40 and 8 elements -> only one word, at 0x40, containing only the new data; no o_done from the aborted run.
